// File: rtl/periph_bus_arbiter.sv
// Round-robin arbiter sharing one peripheral slave port between NUM_MASTERS masters,
// with a registered per-transaction grant and an optional no-response timeout.
module periph_bus_arbiter #(
   parameter int NUM_MASTERS    = 2,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_MASTERS-1:0]    m_read_request_i,
   input  logic [NUM_MASTERS-1:0]    m_write_request_i,
   input  logic [32*NUM_MASTERS-1:0] m_address_i,
   input  logic [32*NUM_MASTERS-1:0] m_write_data_i,
   output logic [32*NUM_MASTERS-1:0] m_read_data_o,
   output logic [NUM_MASTERS-1:0]    m_response_o,
   output logic [NUM_MASTERS-1:0]    m_error_o,
   output logic                      s_read_request_o,
   output logic                      s_write_request_o,
   output logic [31:0]               s_address_o,
   output logic [31:0]               s_write_data_o,
   input  logic [31:0]               s_read_data_i,
   input  logic                      s_response_i,
   output logic [NUM_MASTERS-1:0]    grant_o
);

   localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_MASTERS - 1);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t                 state;
   logic [NUM_MASTERS-1:0] grant;
   logic [IDX_W-1:0]       win;
   logic [IDX_W-1:0]       ptr;
   logic [IDX_W-1:0]       next_win;
   logic [TMR_W-1:0]       timer;
   logic [NUM_MASTERS-1:0] req;
   logic                   any_req;
   logic                   found;
   logic                   w_rd;
   logic                   w_wr;
   logic [31:0]            w_addr;
   logic [31:0]            w_wdata;
   logic                   active;
   logic                   timeout_hit;
   logic                   done;
   logic                   rd_xfer;

   function automatic logic [IDX_W-1:0] wrap_idx(input int v);
      return IDX_W'(v % NUM_MASTERS);
   endfunction

   assign req     = m_read_request_i | m_write_request_i;
   assign any_req = |req;
   assign grant_o = grant;

   always_comb begin
      next_win = ptr;
      found    = 1'b0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         if (!found && req[wrap_idx(int'(ptr) + k)]) begin
            found    = 1'b1;
            next_win = wrap_idx(int'(ptr) + k);
         end
      end
   end

   // Handshake: a master's read/write request is its valid and must stay high until
   // m_response_o (its ready) pulses; dropping it early aborts the transaction. Towards
   // the slave, s_*_request_o is valid and s_response_i is ready, completing together.
   always_comb begin
      w_rd    = 1'b0;
      w_wr    = 1'b0;
      w_addr  = '0;
      w_wdata = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         w_rd    = w_rd | (grant[i] & m_read_request_i[i]);
         w_wr    = w_wr | (grant[i] & m_write_request_i[i]);
         w_addr  = w_addr  | ({32{grant[i]}} & m_address_i[32*i +: 32]);
         w_wdata = w_wdata | ({32{grant[i]}} & m_write_data_i[32*i +: 32]);
      end
   end

   assign active      = (state == BUSY) && (w_rd || w_wr);
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && active && !s_response_i && (timer == TMR_LAST);
   assign done        = active && (s_response_i || timeout_hit);
   assign rd_xfer     = active && s_response_i && w_rd && !w_wr;

   assign s_write_request_o = active & w_wr;
   assign s_read_request_o  = active & w_rd & ~w_wr;
   assign s_address_o       = active ? w_addr : '0;
   assign s_write_data_o    = active ? w_wdata : '0;
   assign m_response_o      = done ? grant : '0;
   assign m_error_o         = timeout_hit ? grant : '0;

   always_comb begin
      m_read_data_o = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         m_read_data_o[32*i +: 32] = (rd_xfer && grant[i]) ? s_read_data_i : 32'h0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         grant <= '0;
         win   <= '0;
         ptr   <= '0;
         timer <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  state <= BUSY;
                  grant <= NUM_MASTERS'(1) << next_win;
                  win   <= next_win;
                  timer <= '0;
               end
            end
            BUSY: begin
               // Completion, timeout and abort all leave the same way.
               if (!active || done) begin
                  state <= IDLE;
                  grant <= '0;
                  ptr   <= (win == IDX_LAST) ? '0 : win + 1'b1;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Bench for periph_bus_arbiter: directed scenarios then random traffic, all checked
// against a transaction-level reference model of the arbitration rules.
module tb_periph_bus_arbiter;

   localparam int N  = 2;
   localparam int TO = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    m_rd, m_wr;
   logic [32*N-1:0] m_addr, m_wdata, m_rdata;
   logic [N-1:0]    m_resp, m_err, grant;
   logic            s_rd, s_wr, s_resp;
   logic [31:0]     s_addr, s_wdata, s_rdata;

   int checks = 0;
   int errors = 0;

   // Reference model: owner of the port (-1 = free), round-robin start, cycles waited.
   int owner  = -1;
   int rr     = 0;
   int waited = 0;

   logic [N-1:0]    exp_resp, exp_err, exp_grant;
   logic [32*N-1:0] exp_rdata;
   logic            exp_srd, exp_swr;
   logic [31:0]     exp_saddr, exp_swdata;

   logic [1:0]      gseq [6];
   logic [N-1:0]    act;
   logic [N-1:0]    finished;
   logic [1:0]      kind;

   periph_bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(TO)) dut (
      .clk               (clk),
      .rst               (rst),
      .m_read_request_i  (m_rd),
      .m_write_request_i (m_wr),
      .m_address_i       (m_addr),
      .m_write_data_i    (m_wdata),
      .m_read_data_o     (m_rdata),
      .m_response_o      (m_resp),
      .m_error_o         (m_err),
      .s_read_request_o  (s_rd),
      .s_write_request_o (s_wr),
      .s_address_o       (s_addr),
      .s_write_data_o    (s_wdata),
      .s_read_data_i     (s_rdata),
      .s_response_i      (s_resp),
      .grant_o           (grant)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_outputs();
      logic rd, wr;
      exp_resp   = '0;
      exp_err    = '0;
      exp_grant  = '0;
      exp_rdata  = '0;
      exp_srd    = 1'b0;
      exp_swr    = 1'b0;
      exp_saddr  = '0;
      exp_swdata = '0;
      if (owner >= 0) begin
         exp_grant[owner] = 1'b1;
         rd = m_rd[owner];
         wr = m_wr[owner];
         if (rd || wr) begin
            exp_swr    = wr;
            exp_srd    = rd && !wr;
            exp_saddr  = m_addr[32*owner +: 32];
            exp_swdata = m_wdata[32*owner +: 32];
            if (s_resp) begin
               exp_resp[owner] = 1'b1;
               if (rd && !wr) exp_rdata[32*owner +: 32] = s_rdata;
            end else if (TO != 0 && waited == TO - 1) begin
               exp_resp[owner] = 1'b1;
               exp_err[owner]  = 1'b1;
            end
         end
      end
   endtask

   task automatic model_update();
      if (rst) begin
         owner  = -1;
         rr     = 0;
         waited = 0;
      end else if (owner < 0) begin
         for (int k = 0; k < N; k++) begin
            if (owner < 0 && (m_rd[(rr + k) % N] || m_wr[(rr + k) % N])) begin
               owner  = (rr + k) % N;
               waited = 0;
            end
         end
      end else if (!(m_rd[owner] || m_wr[owner]) || exp_resp[owner]) begin
         rr    = (owner + 1) % N;
         owner = -1;
      end else begin
         waited++;
      end
   endtask

   task automatic settle_check();
      #1;
      model_outputs();
      check("s_read_request", s_rd, exp_srd);
      check("s_write_request", s_wr, exp_swr);
      check("s_address", s_addr, exp_saddr);
      check("s_write_data", s_wdata, exp_swdata);
      check("m_response", m_resp, exp_resp);
      check("m_error", m_err, exp_err);
      check("m_read_data", m_rdata, exp_rdata);
      check("grant", grant, exp_grant);
   endtask

   task automatic advance();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   initial begin
      rst     = 1'b1;
      m_rd    = '0;
      m_wr    = '0;
      m_addr  = '0;
      m_wdata = '0;
      s_resp  = 1'b0;
      s_rdata = '0;
      act     = '0;
      @(negedge clk);
      settle_check();
      check("reset_grant", grant, 2'b00);
      check("reset_resp", m_resp, 2'b00);
      advance();
      rst = 1'b0;

      // Master0 write, zero-wait slave
      m_wr            = 2'b01;
      m_addr[31:0]    = 32'h8000_0000;
      m_wdata[31:0]   = 32'h0000_00A5;
      s_resp          = 1'b1;
      settle_check();
      advance();
      settle_check();
      check("t1_swr", s_wr, 1'b1);
      check("t1_swdata", s_wdata, 32'hA5);
      check("t1_saddr", s_addr, 32'h8000_0000);
      check("t1_resp", m_resp, 2'b01);
      check("t1_grant", grant, 2'b01);
      advance();
      m_wr = '0;
      settle_check();
      check("t1_grant_idle", grant, 2'b00);
      check("t1_swr_idle", s_wr, 1'b0);
      advance();

      // Both masters hold reads from reset
      gseq[0] = 2'b00; gseq[1] = 2'b01; gseq[2] = 2'b00;
      gseq[3] = 2'b10; gseq[4] = 2'b00; gseq[5] = 2'b01;
      rst            = 1'b1;
      m_rd           = 2'b11;
      m_addr[31:0]   = 32'h4000_0000;
      m_addr[63:32]  = 32'h4000_0004;
      settle_check();
      advance();
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         s_rdata = (owner == 1) ? 32'h22 : 32'h11;
         settle_check();
         check("t2_grant_seq", grant, gseq[c]);
         if (c == 1) check("t2_rdata_m0", m_rdata, 64'h0000_0000_0000_0011);
         if (c == 3) check("t2_rdata_m1", m_rdata, 64'h0000_0022_0000_0000);
         if (c == 2) check("t2_rdata_idle", m_rdata, 64'h0);
         advance();
      end
      m_rd = '0;
      settle_check();
      advance();

      // Silent slave, master1 read times out
      s_resp  = 1'b0;
      s_rdata = 32'hDEAD_BEEF;
      m_rd    = 2'b10;
      for (int c = 0; c < 6; c++) begin
         if (c == 5) m_rd = '0;
         settle_check();
         if (c >= 1 && c <= 4) check("t3_grant_busy", grant, 2'b10);
         if (c < 4) check("t3_no_resp", m_resp, 2'b00);
         if (c == 4) begin
            check("t3_resp", m_resp, 2'b10);
            check("t3_err", m_err, 2'b10);
            check("t3_rdata", m_rdata, 64'h0);
         end
         if (c == 5) check("t3_grant_idle", grant, 2'b00);
         advance();
      end

      // Master1 write aborted mid-transaction, then contention
      m_wr           = 2'b10;
      m_addr[63:32]  = $urandom;
      m_wdata[63:32] = $urandom;
      settle_check();
      advance();
      settle_check();
      check("t4_swr", s_wr, 1'b1);
      check("t4_grant", grant, 2'b10);
      advance();
      m_wr = '0;
      settle_check();
      check("t4_abort_resp", m_resp, 2'b00);
      check("t4_abort_swr", s_wr, 1'b0);
      advance();
      m_rd = 2'b11;
      settle_check();
      check("t4_idle_grant", grant, 2'b00);
      check("t4_idle_swr", s_wr, 1'b0);
      advance();
      s_resp = 1'b1;
      settle_check();
      check("t4_contention_grant", grant, 2'b01);
      check("t4_contention_resp", m_resp, 2'b01);
      advance();
      m_rd = '0;
      settle_check();
      advance();

      // Reset during BUSY of master1
      s_resp = 1'b0;
      m_rd   = 2'b10;
      settle_check();
      advance();
      settle_check();
      check("t5_grant_busy", grant, 2'b10);
      advance();
      rst = 1'b1;
      settle_check();
      advance();
      rst  = 1'b0;
      m_rd = 2'b11;
      settle_check();
      check("t5_grant_reset", grant, 2'b00);
      check("t5_resp_reset", m_resp, 2'b00);
      check("t5_srd_reset", s_rd, 1'b0);
      advance();
      s_resp = 1'b1;
      settle_check();
      check("t5_grant_after", grant, 2'b01);
      advance();
      m_rd = '0;
      settle_check();
      advance();

      // Read and write together: write wins
      m_rd          = 2'b01;
      m_wr          = 2'b01;
      m_wdata[31:0] = 32'h3C;
      s_rdata       = 32'hFFFF_FFFF;
      settle_check();
      advance();
      settle_check();
      check("t6_swr", s_wr, 1'b1);
      check("t6_srd", s_rd, 1'b0);
      check("t6_swdata", s_wdata, 32'h3C);
      check("t6_rdata", m_rdata, 64'h0);
      check("t6_resp", m_resp, 2'b01);
      advance();
      m_rd = '0;
      m_wr = '0;
      settle_check();
      advance();

      // Random traffic
      for (int cyc = 0; cyc < 3000; cyc++) begin
         rst = ($urandom_range(0, 299) == 0);
         for (int i = 0; i < N; i++) begin
            if (!act[i]) begin
               if ($urandom_range(0, 2) == 0) begin
                  act[i]              = 1'b1;
                  kind                = 2'($urandom_range(1, 3));
                  m_rd[i]             = kind[0];
                  m_wr[i]             = kind[1];
                  m_addr[32*i +: 32]  = $urandom;
                  m_wdata[32*i +: 32] = $urandom;
               end
            end else if ($urandom_range(0, 24) == 0) begin
               act[i]  = 1'b0;
               m_rd[i] = 1'b0;
               m_wr[i] = 1'b0;
            end
         end
         s_resp  = ($urandom_range(0, 2) == 0);
         s_rdata = $urandom;
         settle_check();
         finished = exp_resp;
         advance();
         for (int i = 0; i < N; i++) begin
            if (finished[i]) begin
               act[i]  = 1'b0;
               m_rd[i] = 1'b0;
               m_wr[i] = 1'b0;
            end
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/periph_bus_arbiter.md
Name: periph_bus_arbiter

Overview:
- Round-robin arbiter that shares one peripheral slave port (LEDs, GPIO, timer style: read_request/write_request/response handshake) between NUM_MASTERS bus masters, e.g. core data port and a debug/DMA master.
- Registers one grant per transaction and forwards the winner's request to the slave.
- Returns the slave's response and read data only to the winner.
- Aborts slave transactions that never respond, using a per-transaction timeout with an error flag.

Parameters:
NUM_MASTERS, 2, number of requesting masters (2..4)
TIMEOUT_CYCLES, 16, max BUSY cycles before forced error response; 0 disables timeout

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
m_read_request_i  in  NUM_MASTERS  per-master read request, held until response
m_write_request_i  in  NUM_MASTERS  per-master write request, held until response
m_address_i  in  32*NUM_MASTERS  per-master address, slice i = master i
m_write_data_i  in  32*NUM_MASTERS  per-master write data
m_read_data_o  out  32*NUM_MASTERS  per-master read data
m_response_o  out  NUM_MASTERS  per-master transaction done
m_error_o  out  NUM_MASTERS  per-master timeout flag, valid with response
s_read_request_o  out  1  read request to slave
s_write_request_o  out  1  write request to slave
s_address_o  out  32  address to slave
s_write_data_o  out  32  write data to slave
s_read_data_i  in  32  slave read data
s_response_i  in  1  slave response, may be same-cycle combinational
grant_o  out  NUM_MASTERS  registered one-hot grant (debug/status)

Behaviour:
- Clock/reset: single clock clk; rst synchronous, active-high.
- Reset state:
  - state=IDLE, grant=0, rr pointer=0, timer=0.
  - All outputs 0: s_* zero, m_response_o/m_error_o/m_read_data_o zero.
- Request definition: master i requests when m_read_request_i[i] | m_write_request_i[i].
- IDLE:
  - s_* driven 0.
  - If any master requests, winner = first requester searching from pointer upward with wrap.
  - Registered grant=onehot(winner), timer<=0, next state BUSY.
  - s_response_i ignored in IDLE.
- BUSY, request forwarding:
  - s_address_o/s_write_data_o = winner's slices.
  - s_write_request_o = winner write.
  - s_read_request_o = winner read & ~winner write; write wins if both are high.
- BUSY, slave response:
  - s_response_i=1: combinationally m_response_o[winner]=1.
  - m_read_data_o[winner] = s_read_data_i if the transaction is a read, else 0.
  - Next cycle: IDLE, grant=0, pointer=(winner+1) mod NUM_MASTERS.
- BUSY, timeout:
  - timer increments each BUSY cycle without response.
  - When TIMEOUT_CYCLES≠0 and timer==TIMEOUT_CYCLES-1 and s_response_i=0: m_response_o[winner]=1, m_error_o[winner]=1, read data 0.
  - Then same exit as a normal response.
  - s_response_i in the timeout cycle: normal response, no error.
- BUSY, abort: both winner requests low → no response, s_* low that cycle, next IDLE, pointer advances as on completion.
- Non-winning masters: response/error/read data always 0.
- Latency with zero-wait slave: request cycle N → slave request and response cycle N+1.
  - Mandatory IDLE cycle after each transaction; max one transaction per 2 cycles.
  - A master still requesting after its response re-arbitrates as a new transaction.
- Reset mid-transaction: next cycle IDLE, grant=0, pointer=0, no response issued.
- Timer width: $clog2(TIMEOUT_CYCLES+1), minimum 1.

Test Plan:
1. Master0 writes 0x000000A5 to 0x80000000, zero-wait slave, cycle0 → cycle1 s_write_request_o=1, s_write_data_o=0xA5, m_response_o=01, grant_o=01; cycle2 grant_o=00, s_* low.
2. Both masters hold reads from reset; slave returns 0x11 for addr of m0, 0x22 for m1 → grant_o sequence 01,00,10,00,01. m_read_data_o[0]=0x11 and [1]=0x22 only in their response cycles.
3. TIMEOUT_CYCLES=4, silent slave, master1 read at cycle0 → BUSY cycles1–4; cycle4 m_response_o=10, m_error_o=10, read data 0; cycle5 grant_o=00.
4. Master1 write, slow slave, master1 drops request at cycle2 → no m_response_o; cycle3 IDLE, s_write_request_o=0; next contention grants master0.
5. rst=1 during BUSY (cycle2) → cycle3 all outputs 0, grant_o=00; after rst low, simultaneous requests grant master0 first.
6. Master0 asserts read and write together, data 0x3C → s_write_request_o=1, s_read_request_o=0, m_read_data_o[0]=0 at response.
